// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM port arbiter:
// FSM state encoding and requester-select constants.
package sram_port_arbiter_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : sram_port_arbiter_pkg

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant logic. Grants are combinational from the
// requests; the favoured pointer moves to the loser after every grant.
module sram_rr_arbiter
    import sram_port_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic requestA,
    input  logic requestB,
    output logic grantA,
    output logic grantB
);

    logic favoured;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (enable) begin
            if (requestA && (!requestB || favoured == SEL_A)) begin
                grantA = 1'b1;
            end else if (requestB) begin
                grantB = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            favoured <= SEL_A;
        end else if (grantA) begin
            favoured <= SEL_B;
        end else if (grantB) begin
            favoured <= SEL_A;
        end
    end

endmodule : sram_rr_arbiter

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port (1-cycle read latency) between A and B.
// Optional zero-fill sweep after reset: define SRAM_PORT_ARBITER_INIT_EN.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int nrOfAddressBits = 12,
    parameter int nrOfDataBits    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       requestA,
    input  logic                       requestB,
    input  logic                       writeEnableA,
    input  logic                       writeEnableB,
    input  logic [nrOfAddressBits-1:0] addressA,
    input  logic [nrOfAddressBits-1:0] addressB,
    input  logic [nrOfDataBits-1:0]    dataInA,
    input  logic [nrOfDataBits-1:0]    dataInB,
    output logic                       grantA,
    output logic                       grantB,
    output logic                       readValidA,
    output logic                       readValidB,
    output logic [nrOfDataBits-1:0]    readDataA,
    output logic [nrOfDataBits-1:0]    readDataB,
    output logic                       busy,
    output logic                       sramWriteEnable,
    output logic [nrOfAddressBits-1:0] sramAddress,
    output logic [nrOfDataBits-1:0]    sramDataIn,
    input  logic [nrOfDataBits-1:0]    sramDataOut
);

    state_t                       state;
    logic                         run_enable;
    logic                         sweep_write;
    logic [nrOfAddressBits-1:0]   sweep_address;
    logic [nrOfAddressBits-1:0]   address_hold;
    logic [nrOfDataBits-1:0]      data_hold;
    logic                         pending_a;
    logic                         pending_b;
    logic [nrOfDataBits-1:0]      read_hold_a;
    logic [nrOfDataBits-1:0]      read_hold_b;

    // Gating with reset keeps every output at its reset value in the reset cycle.
    assign run_enable = reset && (state == RUN);
    assign busy       = (state == INIT);

    sram_rr_arbiter u_arbiter (
        .clock    (clock),
        .reset    (reset),
        .enable   (run_enable),
        .requestA (requestA),
        .requestB (requestB),
        .grantA   (grantA),
        .grantB   (grantB)
    );

`ifdef SRAM_PORT_ARBITER_INIT_EN
    localparam logic [nrOfAddressBits-1:0] COUNT_STEP = 1;

    logic [nrOfAddressBits-1:0] init_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= INIT;
            init_count <= '0;
        end else if (state == INIT) begin
            init_count <= init_count + COUNT_STEP;
            if (&init_count) begin
                state <= RUN;
            end
        end
    end

    assign sweep_write   = reset && (state == INIT);
    assign sweep_address = init_count;
`else
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= RUN;
        end
    end

    assign sweep_write   = 1'b0;
    assign sweep_address = '0;
`endif

    always_comb begin
        sramWriteEnable = 1'b0;
        sramAddress     = address_hold;
        sramDataIn      = data_hold;
        if (!reset) begin
            sramAddress = '0;
            sramDataIn  = '0;
        end else if (sweep_write) begin
            sramWriteEnable = 1'b1;
            sramAddress     = sweep_address;
            sramDataIn      = '0;
        end else if (grantA) begin
            sramWriteEnable = writeEnableA;
            sramAddress     = addressA;
            sramDataIn      = dataInA;
        end else if (grantB) begin
            sramWriteEnable = writeEnableB;
            sramAddress     = addressB;
            sramDataIn      = dataInB;
        end
    end

    // Address/data registers follow the port so idle cycles repeat the last access.
    always_ff @(posedge clock) begin
        if (!reset) begin
            address_hold <= '0;
            data_hold    <= '0;
        end else begin
            address_hold <= sramAddress;
            data_hold    <= sramDataIn;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_a   <= 1'b0;
            pending_b   <= 1'b0;
            read_hold_a <= '0;
            read_hold_b <= '0;
        end else begin
            pending_a   <= grantA && !writeEnableA;
            pending_b   <= grantB && !writeEnableB;
            read_hold_a <= readDataA;
            read_hold_b <= readDataB;
        end
    end

    // The SRAM presents read data in the cycle after the grant, alongside the pending flag.
    assign readValidA = reset && pending_a;
    assign readValidB = reset && pending_b;
    assign readDataA  = !reset ? '0 : (pending_a ? sramDataOut : read_hold_a);
    assign readDataB  = !reset ? '0 : (pending_b ? sramDataOut : read_hold_b);

endmodule : sram_port_arbiter
